// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline boundary: register ids, ALU op
// encodings and the layout of the latched control-flag bundle.
package id_ex_stage_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int REG_ID_W_DEF = 5;
  localparam int ALU_OP_W_DEF = 4;

  localparam logic [REG_ID_W_DEF-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ID_W_DEF-1:0] REG_V0   = 5'd2;
  localparam logic [REG_ID_W_DEF-1:0] REG_A0   = 5'd4;
  localparam logic [REG_ID_W_DEF-1:0] REG_RA   = 5'd31;

  typedef enum logic [ALU_OP_W_DEF-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  // One-bit control flags are latched as a packed vector indexed by these.
  localparam int F_REG_WRITE  = 0;
  localparam int F_MEM_READ   = 1;
  localparam int F_MEM_WRITE  = 2;
  localparam int F_MEM_TO_REG = 3;
  localparam int F_ALU_SRC    = 4;
  localparam int CTRL_FLAG_W  = 5;
  localparam int CTRL_W       = CTRL_FLAG_W + ALU_OP_W_DEF;

  localparam int OP_RS   = 0;
  localparam int OP_RT   = 1;
  localparam int NUM_OPS = 2;

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Selects one EX operand: MEM-stage result, else WB-stage result, else the
// value latched from the register file. Register zero is never forwarded.
module operand_forward
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_ID_W = REG_ID_W_DEF
) (
  input  logic [REG_ID_W-1:0] src_id,
  input  logic [DATA_W-1:0]   reg_value,
  input  logic                mem_reg_write,
  input  logic [REG_ID_W-1:0] mem_write_id,
  input  logic [DATA_W-1:0]   mem_value,
  input  logic                wb_reg_write,
  input  logic [REG_ID_W-1:0] wb_write_id,
  input  logic [DATA_W-1:0]   wb_value,
  output logic [DATA_W-1:0]   fwd_value
);

  logic src_nonzero;
  logic mem_hit;
  logic wb_hit;

  assign src_nonzero = (src_id != REG_ID_W'(REG_ZERO));
  assign mem_hit     = src_nonzero && mem_reg_write && (mem_write_id == src_id);
  assign wb_hit      = src_nonzero && wb_reg_write && (wb_write_id == src_id);

  // MEM holds the younger result, so it outranks WB.
  assign fwd_value = mem_hit ? mem_value :
                     wb_hit  ? wb_value  : reg_value;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, EX-input operand
// forwarding from MEM/WB, bubble insertion and a saturating stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_ID_W = REG_ID_W_DEF,
  parameter int ALU_OP_W = ALU_OP_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_ID_W-1:0] id_rs_id,
  input  logic [REG_ID_W-1:0] id_rt_id,
  input  logic                id_uses_rt,
  input  logic [DATA_W-1:0]   id_rs_value,
  input  logic [DATA_W-1:0]   id_rt_value,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [DATA_W-1:0]   id_pc_plus4,
  input  logic                id_reg_write,
  input  logic [REG_ID_W-1:0] id_write_id,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                flush,
  input  logic                ex_hold,
  input  logic                mem_reg_write,
  input  logic [REG_ID_W-1:0] mem_write_id,
  input  logic [DATA_W-1:0]   mem_value,
  input  logic                wb_reg_write,
  input  logic [REG_ID_W-1:0] wb_write_id,
  input  logic [DATA_W-1:0]   wb_value,
  output logic                stall,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   ex_rs_value,
  output logic [DATA_W-1:0]   ex_rt_value,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [DATA_W-1:0]   ex_pc_plus4,
  output logic [REG_ID_W-1:0] ex_rt_id,
  output logic [REG_ID_W-1:0] ex_write_id,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_alu_src,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [31:0]         stall_count
);

  logic                   valid_reg;
  logic [CTRL_FLAG_W-1:0] flags_reg;
  logic [ALU_OP_W-1:0]    alu_op_reg;
  logic [DATA_W-1:0]      imm_reg;
  logic [DATA_W-1:0]      pc_plus4_reg;
  logic [REG_ID_W-1:0]    write_id_reg;
  logic [REG_ID_W-1:0]    src_id_reg    [NUM_OPS];
  logic [DATA_W-1:0]      src_value_reg [NUM_OPS];
  logic [DATA_W-1:0]      src_fwd       [NUM_OPS];
  logic [REG_ID_W-1:0]    id_src_id     [NUM_OPS];
  logic [DATA_W-1:0]      id_src_value  [NUM_OPS];
  logic [CTRL_FLAG_W-1:0] id_flags;
  logic [31:0]            stall_count_reg;
  logic                   load_use;

  assign id_src_id[OP_RS]    = id_rs_id;
  assign id_src_id[OP_RT]    = id_rt_id;
  assign id_src_value[OP_RS] = id_rs_value;
  assign id_src_value[OP_RT] = id_rt_value;

  assign id_flags[F_REG_WRITE]  = id_reg_write;
  assign id_flags[F_MEM_READ]   = id_mem_read;
  assign id_flags[F_MEM_WRITE]  = id_mem_write;
  assign id_flags[F_MEM_TO_REG] = id_mem_to_reg;
  assign id_flags[F_ALU_SRC]    = id_alu_src;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_fwd
      operand_forward #(
        .DATA_W   (DATA_W),
        .REG_ID_W (REG_ID_W)
      ) u_fwd (
        .src_id        (src_id_reg[gi]),
        .reg_value     (src_value_reg[gi]),
        .mem_reg_write (mem_reg_write),
        .mem_write_id  (mem_write_id),
        .mem_value     (mem_value),
        .wb_reg_write  (wb_reg_write),
        .wb_write_id   (wb_write_id),
        .wb_value      (wb_value),
        .fwd_value     (src_fwd[gi])
      );
    end
  endgenerate

  // A load in EX cannot feed its result to the instruction now in ID.
  assign load_use = valid_reg && flags_reg[F_MEM_READ] &&
                    (write_id_reg != REG_ID_W'(REG_ZERO)) && id_valid &&
                    ((write_id_reg == id_rs_id) ||
                     (id_uses_rt && (write_id_reg == id_rt_id)));

  assign stall = (load_use || ex_hold) && !flush && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg       <= 1'b0;
      flags_reg       <= '0;
      alu_op_reg      <= '0;
      imm_reg         <= '0;
      pc_plus4_reg    <= '0;
      write_id_reg    <= '0;
      stall_count_reg <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        src_id_reg[i]    <= '0;
        src_value_reg[i] <= '0;
      end
    end else begin
      if (stall && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
      if (ex_hold) begin
        // Fold in any forward seen this cycle so a WB write is not lost.
        for (int i = 0; i < NUM_OPS; i++) begin
          src_value_reg[i] <= src_fwd[i];
        end
      end else if (flush || load_use) begin
        valid_reg  <= 1'b0;
        flags_reg  <= '0;
        alu_op_reg <= '0;
      end else begin
        valid_reg    <= id_valid;
        flags_reg    <= id_flags;
        alu_op_reg   <= id_alu_op;
        imm_reg      <= id_imm;
        pc_plus4_reg <= id_pc_plus4;
        write_id_reg <= id_write_id;
        for (int i = 0; i < NUM_OPS; i++) begin
          src_id_reg[i]    <= id_src_id[i];
          src_value_reg[i] <= id_src_value[i];
        end
      end
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_rs_value   = src_fwd[OP_RS];
  assign ex_rt_value   = src_fwd[OP_RT];
  assign ex_imm        = imm_reg;
  assign ex_pc_plus4   = pc_plus4_reg;
  assign ex_rt_id      = src_id_reg[OP_RT];
  assign ex_write_id   = write_id_reg;
  assign ex_reg_write  = valid_reg && flags_reg[F_REG_WRITE];
  assign ex_mem_read   = valid_reg && flags_reg[F_MEM_READ];
  assign ex_mem_write  = valid_reg && flags_reg[F_MEM_WRITE];
  assign ex_mem_to_reg = valid_reg && flags_reg[F_MEM_TO_REG];
  assign ex_alu_src    = valid_reg && flags_reg[F_ALU_SRC];
  assign ex_alu_op     = alu_op_reg;
  assign stall_count   = stall_count_reg;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline boundary directly downstream of the decode-stage register file. Captures rs/rt operand values, immediate, PC+4 and decoded control from ID into the ID/EX register.
- Detects load-use hazards and generates the upstream stall.
- Applies EX-input forwarding from the MEM and WB stages.
- Inserts bubbles on stall or flush, and counts stall cycles for performance monitoring.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_ID_W, 5, register id width
ALU_OP_W, 4, ALU operation code width

Ports:
clock  in  1  pipeline clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs_id  in  REG_ID_W  rs id sent to the register file
id_rt_id  in  REG_ID_W  rt id sent to the register file
id_uses_rt  in  1  instruction reads rt as a source
id_rs_value  in  DATA_W  rs value from the register file
id_rt_value  in  DATA_W  rt value from the register file
id_imm  in  DATA_W  sign/zero-extended immediate
id_pc_plus4  in  DATA_W  PC+4 of the ID instruction
id_reg_write  in  1  instruction writes a register
id_write_id  in  REG_ID_W  destination register
id_mem_read  in  1  load
id_mem_write  in  1  store
id_mem_to_reg  in  1  WB selects memory data
id_alu_src  in  1  ALU B selects immediate
id_alu_op  in  ALU_OP_W  ALU operation
flush  in  1  branch/jump resolved taken; squash ID
ex_hold  in  1  EX cannot accept (multi-cycle op)
mem_reg_write, mem_write_id, mem_value  in  1/REG_ID_W/DATA_W  MEM-stage forward source
wb_reg_write, wb_write_id, wb_value  in  1/REG_ID_W/DATA_W  WB-stage forward source
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  ID/EX holds a real instruction
ex_rs_value, ex_rt_value  out  DATA_W  forwarded operand values
ex_imm, ex_pc_plus4  out  DATA_W  latched fields
ex_rt_id, ex_write_id  out  REG_ID_W  latched ids
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1  latched control; forced 0 when !ex_valid
ex_alu_op  out  ALU_OP_W  latched ALU operation
stall_count  out  32  saturating count of stall cycles

Behaviour:
- Reset (synchronous, priority over everything): all ID/EX fields, ex_valid and stall_count go to 0. stall is 0 while reset is high.
- Load-use hazard (combinational) is set when all of these hold: ex_valid, ex_mem_read, ex_write_id != 0, id_valid, and (ex_write_id == id_rs_id, or id_uses_rt with ex_write_id == id_rt_id).
- stall = (load_use | ex_hold) & !flush & !reset.
- Posedge update, in priority order:
  - reset.
  - ex_hold: ID/EX fields are held, except that the rs/rt data fields reload their own forwarded outputs, so a WB write during the hold is not lost.
  - flush or load_use: bubble. ex_valid and all control bits go to 0; data fields are don't-care.
  - Otherwise: capture all ID fields. ex_valid <= id_valid.
- flush together with ex_hold: hold wins for ID/EX. The upstream squash is the IF/ID owner's job.
- Latency: one cycle from ID capture to the ex_* outputs.
- Forwarding (combinational, per operand, using the latched rs/rt ids):
  - MEM match (mem_reg_write, mem_write_id == id, id != 0) selects mem_value.
  - Otherwise a WB match selects wb_value.
  - Otherwise the latched register-file value is used.
  - MEM has priority over WB. Register 0 is never forwarded.
- No WB-to-ID bypass is needed: the register file writes on negedge, so id_*_value is stable by posedge.
- stall_count increments on each posedge where stall = 1 and saturates at 0xFFFFFFFF.

Decomposition:
- Shared package/header holds:
  - register id constants: REG_ZERO=0, v0=2, a0=4, ra=31
  - ALU op encodings
  - ID/EX control-bundle field widths
- One sub-module, operand_forward: ids, latched value and the two forward sources in, selected value out. It is instantiated twice (rs, rt).

Test Plan:
- Reset high 2 cycles with id_valid=1 -> ex_valid=0, all ex_* control 0, stall_count=0, stall=0.
- lw $8 captured, next ID add $9,$8,$10 (rs=8) -> stall=1 for 1 cycle, bubble (ex_valid=0), add captured the following cycle, stall_count=1.
- ex_mem_read with ex_write_id=0 and id_rs_id=0 -> stall=0 ($zero never hazards).
- ex_rs_id=5, mem_write_id=5 with mem_value=0x11, wb_write_id=5 with wb_value=0x22 -> ex_rs_value=0x11; drop MEM match -> 0x22; both mem_reg_write and wb_reg_write off -> latched register-file value.
- ex_hold=1 for 3 cycles while WB writes $6=0xABCD and ex_rt_id=6 -> after hold, ex_rt_value=0xABCD; stall=1 for all 3 cycles; stall_count +3.
- flush=1 with a load-use hazard also present -> stall=0, next-cycle ex_valid=0, stall_count unchanged.
